// File: rtl/picobello_pkg.sv
// rtl/picobello_pkg.sv - picobello mesh and multicast address-map constants
package picobello_pkg;

    localparam int unsigned MeshDimX = 4;
    localparam int unsigned MeshDimY = 4;

    // Multicast SAM entry: where the tile coordinates live inside an address.
    localparam int unsigned SamMcastMaskXOffset = 20;
    localparam int unsigned SamMcastMaskXLen    = 2;
    localparam int unsigned SamMcastMaskYOffset = 18;
    localparam int unsigned SamMcastMaskYLen    = 2;

    localparam int unsigned PbAddrWidth = 48;
    localparam int unsigned PbNumX      = MeshDimX;
    localparam int unsigned PbNumY      = MeshDimY;
    localparam int unsigned PbXOffset   = SamMcastMaskXOffset;
    localparam int unsigned PbXLen      = SamMcastMaskXLen;
    localparam int unsigned PbYOffset   = SamMcastMaskYOffset;
    localparam int unsigned PbYLen      = SamMcastMaskYLen;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_SCAN,
        MC_DRAIN
    } mc_state_e;

endpackage

// File: rtl/pb_mcast_masked_incr.sv
// rtl/pb_mcast_masked_incr.sv - next coordinate under a don't-care mask
module pb_mcast_masked_incr #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] c_i,
    input  logic [Width-1:0] m_i,
    input  logic [Width-1:0] base_i,
    output logic [Width-1:0] next_o,
    output logic             is_final_o
);

    // Forcing the fixed bits to 1 lets the carry ripple only through masked bits.
    assign next_o     = (((c_i | ~m_i) + Width'(1)) & m_i) | (base_i & ~m_i);
    assign is_final_o = (c_i == (base_i | m_i));

endmodule

// File: rtl/pb_mcast_expander.sv
// rtl/pb_mcast_expander.sv - expands a masked multicast request into unicast tiles
module pb_mcast_expander
    import picobello_pkg::*;
#(
    parameter int unsigned AddrWidth = PbAddrWidth,
    parameter int unsigned NumX      = PbNumX,
    parameter int unsigned NumY      = PbNumY,
    parameter int unsigned XOffset   = PbXOffset,
    parameter int unsigned XLen      = PbXLen,
    parameter int unsigned YOffset   = PbYOffset,
    parameter int unsigned YLen      = PbYLen
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [AddrWidth-1:0] in_mask_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [XLen-1:0]      out_x_o,
    output logic [YLen-1:0]      out_y_o,
    output logic                 out_last_o,
    output logic                 err_o
);

    localparam int unsigned CW = XLen + YLen;

    mc_state_e            state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [CW-1:0]        mask_q, mask_d;
    logic [CW-1:0]        cand_q, cand_d;
    logic [CW-1:0]        pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 err_q, err_d;

    logic [CW-1:0] in_c, in_m, base_c, next_c;
    logic          is_final, cand_ok, advance;
    logic          unused_mask_bits;

    assign in_c   = {in_addr_i[YOffset +: YLen], in_addr_i[XOffset +: XLen]};
    assign in_m   = {in_mask_i[YOffset +: YLen], in_mask_i[XOffset +: XLen]};
    assign base_c = {addr_q[YOffset +: YLen], addr_q[XOffset +: XLen]};

    // Only the coordinate fields of the mask matter.
    assign unused_mask_bits = ^in_mask_i;

    assign cand_ok = (32'(cand_q[XLen-1:0]) < NumX) && (32'(cand_q[CW-1:XLen]) < NumY);

    pb_mcast_masked_incr #(
        .Width (CW)
    ) u_incr (
        .c_i        (cand_q),
        .m_i        (mask_q),
        .base_i     (base_c),
        .next_o     (next_c),
        .is_final_o (is_final)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        cand_d      = cand_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        err_d       = 1'b0;
        advance     = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;

        case (state_q)
            MC_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    addr_d   = in_addr_i;
                    mask_d   = in_m;
                    cand_d   = in_c & ~in_m;
                    pend_v_d = 1'b0;
                    state_d  = MC_SCAN;
                end
            end
            MC_SCAN: begin
                if (!cand_ok) begin
                    advance = 1'b1;
                end else if (!pend_v_q) begin
                    pend_d   = cand_q;
                    pend_v_d = 1'b1;
                    advance  = 1'b1;
                end else begin
                    // One destination is held back so the final one can carry last.
                    out_valid_o = 1'b1;
                    if (out_ready_i) begin
                        pend_d  = cand_q;
                        advance = 1'b1;
                    end
                end
                if (advance) begin
                    if (is_final) begin
                        if (pend_v_d) begin
                            state_d = MC_DRAIN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = MC_IDLE;
                        end
                    end else begin
                        cand_d = next_c;
                    end
                end
            end
            MC_DRAIN: begin
                out_valid_o = 1'b1;
                out_last_o  = 1'b1;
                if (out_ready_i) begin
                    pend_v_d = 1'b0;
                    state_d  = MC_IDLE;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_comb begin
        out_addr_o                   = addr_q;
        out_addr_o[XOffset +: XLen]  = pend_q[XLen-1:0];
        out_addr_o[YOffset +: YLen]  = pend_q[CW-1:XLen];
    end

    assign out_x_o = pend_q[XLen-1:0];
    assign out_y_o = pend_q[CW-1:XLen];
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= MC_IDLE;
            addr_q   <= '0;
            mask_q   <= '0;
            cand_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            cand_q   <= cand_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/pb_mcast_expander.md
PB_MCAST_EXPANDER -- requirements
Module: pb_mcast_expander

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, meaning width of request and output addresses.
REQ-002 SHALL have parameter NumX, default 4, meaning mesh columns that hold cluster tiles (any value from 1 to 2**XLen).
REQ-003 SHALL have parameter NumY, default 4, meaning mesh rows that hold cluster tiles (any value from 1 to 2**YLen).
REQ-004 SHALL have parameters XOffset (default 20), XLen (default 2), YOffset (default 18) and YLen (default 2), meaning the bit positions and widths of the X and Y tile coordinates inside an address.
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid_i  in  1  multicast request valid.
REQ-008 SHALL have port in_ready_o  out  1  request accepted.
REQ-009 SHALL have port in_addr_i  in  AddrWidth  base address.
REQ-010 SHALL have port in_mask_i  in  AddrWidth  multicast mask; a set bit means "don't care".
REQ-011 SHALL have port out_valid_o  out  1  unicast destination valid.
REQ-012 SHALL have port out_ready_i  in  1  downstream accepts the destination.
REQ-013 SHALL have port out_addr_o  out  AddrWidth  in_addr with its coordinate fields replaced by the destination coordinates.
REQ-014 SHALL have ports out_x_o  out  XLen and out_y_o  out  YLen, the destination coordinates.
REQ-015 SHALL have port out_last_o  out  1  marks the final destination of a request.
REQ-016 SHALL have port err_o  out  1  one-cycle pulse when a request has no in-range destination.

Function
REQ-017 SHALL define the coordinate vector c = {y, x} and the mask vector m = {mask_y, mask_x}, each taken from its fields of the address or mask.
REQ-018 SHALL enumerate candidates starting from base & ~m, with next = (((c | ~m) + 1) & m) | (base & ~m), so that x varies fastest; the final candidate is base | m.
REQ-019 SHALL treat a candidate as in range if and only if x < NumX and y < NumY; out-of-range candidates SHALL be skipped silently.
REQ-020 SHALL evaluate one candidate per cycle while in state SCAN and not stalled.
REQ-021 SHALL implement the three states IDLE, SCAN and DRAIN.
REQ-022 In IDLE, in_ready_o SHALL be 1; on in_valid_i the block SHALL latch addr and mask, set cand to the first candidate, clear pend_v and move to SCAN.
REQ-023 In SCAN, when cand is in range and pend_v=0, the block SHALL set pend to cand and pend_v to 1, then advance.
REQ-024 In SCAN, when cand is in range and pend_v=1, the block SHALL drive out_valid_o=1 with pend and out_last_o=0; on out_ready_i it SHALL load pend with cand and advance, otherwise it SHALL hold cand and pend.
REQ-025 When advancing past the final candidate, the block SHALL move to DRAIN if pend_v=1 (counting a pend set in that same cycle); otherwise it SHALL pulse err_o and move to IDLE.
REQ-026 In DRAIN, the block SHALL drive out_valid_o=1 with pend and out_last_o=1; on out_ready_i it SHALL move to IDLE.
REQ-027 out_* SHALL come only from the pend register and SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-028 in_ready_o SHALL be 0 in SCAN and DRAIN; one request is in flight at a time.
REQ-029 Mask bits outside the X and Y fields SHALL be ignored; out_addr_o SHALL copy all non-coordinate bits from the latched address.
REQ-030 With m=0, the first output SHALL appear 2 cycles after acceptance, with out_last_o=1.

Reset
REQ-031 While rst_ni=0 at a rising clock edge, the state SHALL become IDLE and pend_v, out_valid_o and err_o SHALL become 0, including mid-request; the pending request SHALL be dropped.
REQ-032 The first cycle after reset SHALL present in_ready_o=1.

Structure
REQ-033 The address-field parameters SHALL be derived in picobello_pkg from the multicast SAM mask_x/mask_y offsets and lengths, and NumX/NumY from MeshDim, all as localparams.
REQ-034 The masked-increment candidate generator SHALL be one natural sub-module, pb_mcast_masked_incr (combinational: c, m, base -> next, is_final).

Verification
REQ-035 Unicast: addr X=2,Y=1, mask 0 -> one output (2,1), last=1, 2 cycles after acceptance.
REQ-036 Mask on the X field = 2'b11, Y=3 -> outputs (0,3),(1,3),(2,3),(3,3) in order, last only on (3,3).
REQ-037 Full mask, NumX=3, NumY=4 -> 12 outputs in x-fastest order, with no x=3 output and last on (2,3).
REQ-038 NumX=3, addr X=3, mask 0 -> no output, err_o pulses once, return to IDLE.
REQ-039 Random out_ready_i backpressure during REQ-036 -> out_* stable while stalled, no loss and no duplicates.
REQ-040 rst_ni low in DRAIN -> out_valid_o=0 at the next edge, then in_ready_o=1.
